// File: rtl/fir_dma_pkg.sv
// Shared state encoding and FIR CSR layout for the FIR DMA master.
package fir_dma_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_COEF0,
        ST_COEF1,
        ST_RD_SRC,
        ST_WT_SRC,
        ST_WR_X,
        ST_SETTLE,
        ST_RD_Y,
        ST_WT_Y,
        ST_WR_DST,
        ST_DONE
    } fir_dma_state_e;

    localparam logic [31:0] FIR_COEF_LO = 32'd0;
    localparam logic [31:0] FIR_COEF_HI = 32'd1;
    localparam logic [31:0] FIR_X       = 32'd2;
    localparam logic [31:0] FIR_Y       = 32'd3;

    localparam logic [31:0] BYTE_STRIDE = 32'd4;

    function automatic logic [31:0] csr_addr(input logic [31:0] base,
                                             input logic [31:0] word_off);
        return base + word_off * BYTE_STRIDE;
    endfunction

endpackage

// File: rtl/fir_dma_master.sv
// Avalon-MM initiator: loads the FIR coefficients, then streams each sample
// through the FIR CSR and stores the filtered result to destination memory.
module fir_dma_master
    import fir_dma_pkg::*;
#(
    parameter logic [31:0] FIR_BASE = 32'h0001_0000,
    parameter int unsigned FIR_LAT  = 2,
    parameter int unsigned LEN_W    = 16
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [31:0]      SrcAddr,
    input  logic [31:0]      DstAddr,
    input  logic [LEN_W-1:0] Length,
    input  logic [31:0]      Coef0,
    input  logic [31:0]      Coef1,
    output logic             Busy,
    output logic             Done,
    output logic [31:0]      Address,
    output logic             Read,
    output logic             Write,
    output logic [31:0]      WriteData,
    input  logic             WaitRequest,
    input  logic [31:0]      ReadData,
    input  logic             ReadDataValid
);

    localparam int unsigned SET_W = (FIR_LAT < 2) ? 1 : $clog2(FIR_LAT + 1);

    localparam logic [31:0] ADDR_COEF_LO = csr_addr(FIR_BASE, FIR_COEF_LO);
    localparam logic [31:0] ADDR_COEF_HI = csr_addr(FIR_BASE, FIR_COEF_HI);
    localparam logic [31:0] ADDR_X       = csr_addr(FIR_BASE, FIR_X);
    localparam logic [31:0] ADDR_Y       = csr_addr(FIR_BASE, FIR_Y);

    fir_dma_state_e     r_state;
    fir_dma_state_e     w_state_nxt;

    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [LEN_W-1:0]   r_rem;
    logic [SET_W-1:0]   r_set;
    logic [7:0]         r_x;
    logic [31:0]        r_y;
    logic [31:0]        r_coef0;
    logic [31:0]        r_coef1;

    logic [31:0]        r_addr;
    logic               r_read;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic               r_busy;
    logic               r_done;

    logic [31:0]        w_src_nxt;
    logic [31:0]        w_dst_nxt;
    logic [LEN_W-1:0]   w_rem_nxt;
    logic [SET_W-1:0]   w_set_nxt;
    logic [7:0]         w_x_nxt;
    logic [31:0]        w_y_nxt;
    logic [31:0]        w_coef0_nxt;
    logic [31:0]        w_coef1_nxt;

    logic [31:0]        w_addr_nxt;
    logic               w_read_nxt;
    logic               w_write_nxt;
    logic [31:0]        w_wdata_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [7:0]         w_unused_rdata;

    assign w_unused_rdata = ReadData[31:24];

    assign Address   = r_addr;
    assign Read      = r_read;
    assign Write     = r_write;
    assign WriteData = r_wdata;
    assign Busy      = r_busy;
    assign Done      = r_done;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_set   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_coef0 <= '0;
            r_coef1 <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_rem   <= w_rem_nxt;
            r_set   <= w_set_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_coef0 <= w_coef0_nxt;
            r_coef1 <= w_coef1_nxt;
            r_addr  <= w_addr_nxt;
            r_read  <= w_read_nxt;
            r_write <= w_write_nxt;
            r_wdata <= w_wdata_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_rem_nxt   = r_rem;
        w_set_nxt   = r_set;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_coef0_nxt = r_coef0;
        w_coef1_nxt = r_coef1;

        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_src_nxt   = SrcAddr;
                    w_dst_nxt   = DstAddr;
                    w_rem_nxt   = Length;
                    w_coef0_nxt = Coef0;
                    w_coef1_nxt = Coef1;
                    w_state_nxt = ST_COEF0;
                end
            end
            ST_COEF0: begin
                if (!WaitRequest) w_state_nxt = ST_COEF1;
            end
            ST_COEF1: begin
                if (!WaitRequest) begin
                    w_state_nxt = (r_rem == '0) ? ST_DONE : ST_RD_SRC;
                end
            end
            ST_RD_SRC: begin
                if (!WaitRequest) w_state_nxt = ST_WT_SRC;
            end
            ST_WT_SRC: begin
                if (ReadDataValid) begin
                    w_x_nxt     = ReadData[7:0];
                    w_state_nxt = ST_WR_X;
                end
            end
            ST_WR_X: begin
                if (!WaitRequest) begin
                    if (FIR_LAT == 0) begin
                        w_state_nxt = ST_RD_Y;
                    end else begin
                        w_set_nxt   = SET_W'(FIR_LAT);
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_set <= SET_W'(1)) begin
                    w_set_nxt   = '0;
                    w_state_nxt = ST_RD_Y;
                end else begin
                    w_set_nxt   = r_set - SET_W'(1);
                end
            end
            ST_RD_Y: begin
                if (!WaitRequest) w_state_nxt = ST_WT_Y;
            end
            ST_WT_Y: begin
                if (ReadDataValid) begin
                    w_y_nxt     = {8'h00, ReadData[23:0]};
                    w_state_nxt = ST_WR_DST;
                end
            end
            ST_WR_DST: begin
                if (!WaitRequest) begin
                    w_src_nxt   = r_src + BYTE_STRIDE;
                    w_dst_nxt   = r_dst + BYTE_STRIDE;
                    w_rem_nxt   = r_rem - LEN_W'(1);
                    w_state_nxt = (w_rem_nxt == '0) ? ST_DONE : ST_RD_SRC;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are registered, so they are decoded from the state being
    // entered and the register values that will hold in it.
    always_comb begin
        w_addr_nxt  = '0;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_wdata_nxt = '0;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;

        case (w_state_nxt)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            ST_COEF0: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = ADDR_COEF_LO;
                w_wdata_nxt = w_coef0_nxt;
            end
            ST_COEF1: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = ADDR_COEF_HI;
                w_wdata_nxt = w_coef1_nxt;
            end
            ST_RD_SRC: begin
                w_read_nxt = 1'b1;
                w_addr_nxt = w_src_nxt;
            end
            ST_WR_X: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = ADDR_X;
                w_wdata_nxt = {24'h000000, w_x_nxt};
            end
            ST_RD_Y: begin
                w_read_nxt = 1'b1;
                w_addr_nxt = ADDR_Y;
            end
            ST_WR_DST: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = w_dst_nxt;
                w_wdata_nxt = w_y_nxt;
            end
            ST_DONE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_dma_master.sv
// Bench for fir_dma_master: Avalon slave model with random stalls, a
// transaction-level expectation built from the job description, and checks.
module tb_fir_dma_master;

    localparam logic [31:0] FIR_BASE = 32'h0001_0000;
    localparam int unsigned FIR_LAT  = 2;
    localparam int unsigned LEN_W    = 16;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } tx_t;

    logic             clk = 1'b0;
    logic             Rst = 1'b1;
    logic             Start = 1'b0;
    logic [31:0]      SrcAddr = '0;
    logic [31:0]      DstAddr = '0;
    logic [LEN_W-1:0] Length = '0;
    logic [31:0]      Coef0 = '0;
    logic [31:0]      Coef1 = '0;
    logic             Busy;
    logic             Done;
    logic [31:0]      Address;
    logic             Read;
    logic             Write;
    logic [31:0]      WriteData;
    logic             WaitRequest = 1'b0;
    logic [31:0]      ReadData = '0;
    logic             ReadDataValid = 1'b0;

    int tests = 0;
    int fails = 0;

    tx_t         exp_q[$];
    tx_t         log_q[$];
    logic [31:0] samp[$];
    logic [31:0] yv[$];
    logic [31:0] mem[logic [31:0]];
    int          y_idx = 0;
    bit          stall_en = 1'b0;
    int          stab_err = 0;
    int          rw_err = 0;

    bit          req_new = 1'b1;
    int          stall_left = 0;
    logic [65:0] snap;
    bit          rd_pend = 1'b0;
    int          rd_dly = 0;
    logic [31:0] rd_word = '0;

    fir_dma_master #(
        .FIR_BASE (FIR_BASE),
        .FIR_LAT  (FIR_LAT),
        .LEN_W    (LEN_W)
    ) dut (
        .clk           (clk),
        .Rst           (Rst),
        .Start         (Start),
        .SrcAddr       (SrcAddr),
        .DstAddr       (DstAddr),
        .Length        (Length),
        .Coef0         (Coef0),
        .Coef1         (Coef1),
        .Busy          (Busy),
        .Done          (Done),
        .Address       (Address),
        .Read          (Read),
        .Write         (Write),
        .WriteData     (WriteData),
        .WaitRequest   (WaitRequest),
        .ReadData      (ReadData),
        .ReadDataValid (ReadDataValid)
    );

    always #5 clk = ~clk;

    // Slave: memory for source words, FIR Yn register, random stalls.
    always @(negedge clk) begin
        if (Rst) begin
            WaitRequest   = 1'b0;
            ReadDataValid = 1'b0;
            rd_pend       = 1'b0;
            req_new       = 1'b1;
            stall_left    = 0;
        end else begin
            ReadDataValid = 1'b0;
            if (rd_pend) begin
                if (rd_dly == 0) begin
                    ReadDataValid = 1'b1;
                    ReadData      = rd_word;
                    rd_pend       = 1'b0;
                end else begin
                    rd_dly--;
                end
            end else if (stall_en && $urandom_range(0, 3) == 0) begin
                ReadDataValid = 1'b1;
                ReadData      = $urandom;
            end
            if (Read && Write) rw_err++;
            if (Read || Write) begin
                if (req_new) begin
                    req_new    = 1'b0;
                    stall_left = stall_en ? int'($urandom_range(0, 5)) : 0;
                    snap       = {Address, WriteData, Read, Write};
                end else if ({Address, WriteData, Read, Write} !== snap) begin
                    stab_err++;
                end
                if (stall_left > 0) begin
                    WaitRequest = 1'b1;
                    stall_left--;
                end else begin
                    WaitRequest = 1'b0;
                    req_new     = 1'b1;
                    log_q.push_back('{Write, Address, Write ? WriteData : 32'h0});
                    if (Read) begin
                        rd_pend = 1'b1;
                        rd_dly  = stall_en ? int'($urandom_range(0, 3)) : 0;
                        if (Address == FIR_BASE + 32'd12) begin
                            rd_word = (y_idx < yv.size()) ? yv[y_idx] : $urandom;
                            y_idx++;
                        end else begin
                            rd_word = mem.exists(Address) ? mem[Address] : $urandom;
                        end
                    end
                end
            end else begin
                WaitRequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Random upper bits on every returned word exercise the masking rules.
    task automatic prep(input int len);
        samp.delete();
        yv.delete();
        for (int i = 0; i < len; i++) begin
            samp.push_back($urandom);
            yv.push_back($urandom);
        end
    endtask

    task automatic run_job(input string name, input logic [31:0] src, input logic [31:0] dst,
                           input int len, input logic [31:0] c0, input logic [31:0] c1,
                           input bit stall, input int exp_cycles, input bit poke);
        int cyc;
        int n;
        exp_q.delete();
        exp_q.push_back('{1'b1, FIR_BASE, c0});
        exp_q.push_back('{1'b1, FIR_BASE + 32'd4, c1});
        mem.delete();
        for (int i = 0; i < len; i++) begin
            logic [31:0] sa;
            logic [31:0] da;
            sa = src + 32'(4 * i);
            da = dst + 32'(4 * i);
            mem[sa] = samp[i];
            exp_q.push_back('{1'b0, sa, 32'h0});
            exp_q.push_back('{1'b1, FIR_BASE + 32'd8, {24'h0, samp[i][7:0]}});
            exp_q.push_back('{1'b0, FIR_BASE + 32'd12, 32'h0});
            exp_q.push_back('{1'b1, da, {8'h0, yv[i][23:0]}});
        end
        log_q.delete();
        y_idx    = 0;
        stall_en = stall;
        stab_err = 0;
        rw_err   = 0;

        @(negedge clk);
        Start   = 1'b1;
        SrcAddr = src;
        DstAddr = dst;
        Length  = LEN_W'(len);
        Coef0   = c0;
        Coef1   = c1;
        @(negedge clk);
        Start   = 1'b0;
        SrcAddr = $urandom;
        DstAddr = $urandom;
        Length  = LEN_W'($urandom);
        Coef0   = $urandom;
        Coef1   = $urandom;
        check({name, "_busy_after_start"}, 96'(Busy), 96'(1'b1));
        cyc = 1;
        while (Done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            Start = (poke && cyc == 6);
        end
        Start = 1'b0;
        check({name, "_done_seen"}, 96'(Done), 96'(1'b1));
        if (exp_cycles >= 0) check({name, "_cycles"}, 96'(cyc), 96'(exp_cycles));
        check({name, "_busy_at_done"}, 96'(Busy), 96'(1'b0));
        @(negedge clk);
        check({name, "_done_pulse_end"}, 96'({Done, Busy}), 96'(2'b00));
        repeat (4) @(negedge clk);
        stall_en = 1'b0;
        @(negedge clk);
        check({name, "_tx_count"}, 96'(log_q.size()), 96'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_tx%0d", name, i), 96'(log_q[i]), 96'(exp_q[i]));
        end
        check({name, "_stall_stable"}, 96'(stab_err), 96'(0));
        check({name, "_rd_wr_exclusive"}, 96'(rw_err), 96'(0));
    endtask

    initial begin
        logic [31:0] rs;
        logic [31:0] rd;
        int          rl;
        int          xw;
        int          guard;

        Rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", 96'({Address, Read, Write, WriteData, Busy, Done}), 96'(0));
        Rst = 1'b0;
        @(negedge clk);

        prep(0);
        run_job("len0", 32'h100, 32'h200, 0, 32'h04030201, 32'h08070605, 1'b0, 3, 1'b0);

        prep(3);
        for (int i = 0; i < 3; i++) begin
            samp[i] = {samp[i][31:8], 8'(i + 1)};
            yv[i]   = {yv[i][31:24], 24'hABCDEF};
        end
        run_job("len3", 32'h100, 32'h400, 3, 32'h11223344, 32'h55667788, 1'b0,
                3 + 3 * (6 + FIR_LAT), 1'b0);
        run_job("len3_stall", 32'h100, 32'h400, 3, 32'h11223344, 32'h55667788, 1'b1, -1, 1'b1);

        prep(2);
        yv[0] = 32'hFF123456;
        run_job("wrap", 32'hFFFF_FFFC, 32'h0000_8000, 2, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0,
                3 + 2 * (6 + FIR_LAT), 1'b0);

        for (int j = 0; j < 3; j++) begin
            rs = 32'h0100_0000 + (32'($urandom_range(0, 1023)) << 2);
            rd = 32'h0200_0000 + (32'($urandom_range(0, 1023)) << 2);
            rl = int'($urandom_range(1, 6));
            prep(rl);
            run_job($sformatf("rand%0d", j), rs, rd, rl, $urandom, $urandom, 1'b1, -1, 1'b1);
        end

        prep(3);
        log_q.delete();
        y_idx = 0;
        mem.delete();
        for (int i = 0; i < 3; i++) mem[32'h300 + 32'(4 * i)] = samp[i];
        @(negedge clk);
        Start   = 1'b1;
        SrcAddr = 32'h300;
        DstAddr = 32'h600;
        Length  = 16'd3;
        Coef0   = 32'h1;
        Coef1   = 32'h2;
        @(negedge clk);
        Start = 1'b0;
        xw    = 0;
        guard = 0;
        while (xw < 2 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
            xw = 0;
            foreach (log_q[k]) if (log_q[k].wr && log_q[k].addr == FIR_BASE + 32'd8) xw++;
        end
        check("rst_reach_settle", 96'(xw), 96'(2));
        @(negedge clk);
        Rst = 1'b1;
        @(negedge clk);
        check("rst_mid_job_outputs", 96'({Address, Read, Write, WriteData, Busy, Done}), 96'(0));
        Rst = 1'b0;
        @(negedge clk);
        prep(3);
        run_job("after_rst", 32'h300, 32'h600, 3, 32'h1, 32'h2, 1'b0,
                3 + 3 * (6 + FIR_LAT), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
